// File: rtl/bnn_uart_pkg.sv
// Shared types and constants for the UART transmit scheduler.
package bnn_uart_pkg;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

   localparam logic UART_IDLE_LVL  = 1'b1;
   localparam logic UART_START_LVL = 1'b0;

   // Clock cycles of line activity per 8N1-style frame (start + data + stop).
   function automatic int unsigned frame_cycles(input int unsigned data_w,
                                                input int unsigned clks_per_bit);
      return (data_w + 2) * clks_per_bit;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping modulo NUM_REQ.
module rr_arbiter #(
   parameter int unsigned NUM_REQ = 2
) (
   input  logic [NUM_REQ-1:0]         req,
   input  logic [$clog2(NUM_REQ)-1:0] ptr,
   output logic [NUM_REQ-1:0]         gnt_c,
   output logic [$clog2(NUM_REQ)-1:0] idx_c
);

   localparam int unsigned PTR_W = $clog2(NUM_REQ);

   int unsigned      pos;
   logic [PTR_W-1:0] pos_idx;
   logic             found;

   always_comb begin
      gnt_c   = '0;
      idx_c   = '0;
      found   = 1'b0;
      pos     = 0;
      pos_idx = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         pos = 32'(ptr) + i;
         if (pos >= NUM_REQ) pos = pos - NUM_REQ;
         pos_idx = PTR_W'(pos);
         if (!found && req[pos_idx]) begin
            found          = 1'b1;
            gnt_c[pos_idx] = 1'b1;
            idx_c          = pos_idx;
         end
      end
   end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin shared UART transmitter: one requester's byte per frame, LSB first,
// with a baud counter realigned at every frame start.
module uart_tx_scheduler
   import bnn_uart_pkg::*;
#(
   parameter int unsigned NUM_REQ      = 2,
   parameter int unsigned DATA_W       = 8,
   parameter int unsigned CLKS_PER_BIT = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*DATA_W-1:0] data,
   output logic [NUM_REQ-1:0]        grant,
   output logic                      tx,
   output logic                      busy,
   output logic                      done
);

   localparam int unsigned PTR_W = $clog2(NUM_REQ);
   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
   localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   if (CLKS_PER_BIT < 2) begin : g_bad_cpb
      $error("uart_tx_scheduler: CLKS_PER_BIT must be >= 2");
   end
   if (NUM_REQ < 2) begin : g_bad_nreq
      $error("uart_tx_scheduler: NUM_REQ must be >= 2");
   end

   tx_state_t          state, state_n;
   logic [CNT_W-1:0]   cnt, cnt_n;
   logic [BIT_W-1:0]   bit_idx, bit_idx_n;
   logic [DATA_W-1:0]  shift, shift_n;
   logic [PTR_W-1:0]   ptr, ptr_n;
   logic [NUM_REQ-1:0] grant_n;
   logic               tx_n, busy_n, done_n;

   logic [NUM_REQ-1:0] gnt_c;
   logic [PTR_W-1:0]   win_c;
   logic [DATA_W-1:0]  win_data_c;
   logic               bit_end_c;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .req   (req),
      .ptr   (ptr),
      .gnt_c (gnt_c),
      .idx_c (win_c)
   );

   // Payload of the arbitration winner.
   always_comb begin
      win_data_c = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (gnt_c[i]) win_data_c = data[i*DATA_W +: DATA_W];
      end
   end

   assign bit_end_c = (cnt == CNT_W'(CLKS_PER_BIT - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shift   <= '0;
         ptr     <= '0;
         grant   <= '0;
         tx      <= UART_IDLE_LVL;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         bit_idx <= bit_idx_n;
         shift   <= shift_n;
         ptr     <= ptr_n;
         grant   <= grant_n;
         tx      <= tx_n;
         busy    <= busy_n;
         done    <= done_n;
      end
   end

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      bit_idx_n = bit_idx;
      shift_n   = shift;
      ptr_n     = ptr;
      grant_n   = '0;
      tx_n      = tx;
      busy_n    = busy;
      done_n    = 1'b0;

      case (state)
         IDLE: begin
            tx_n = UART_IDLE_LVL;
            if (|req) begin
               state_n = START;
               grant_n = gnt_c;
               shift_n = win_data_c;
               tx_n    = UART_START_LVL;
               cnt_n   = '0;
               ptr_n   = (win_c == PTR_W'(NUM_REQ - 1)) ? '0 : win_c + PTR_W'(1);
            end
         end
         START: begin
            cnt_n = cnt + CNT_W'(1);
            if (bit_end_c) begin
               state_n   = DATA;
               cnt_n     = '0;
               bit_idx_n = '0;
               tx_n      = shift[0];
               shift_n   = shift >> 1;
            end
         end
         DATA: begin
            cnt_n = cnt + CNT_W'(1);
            if (bit_end_c) begin
               cnt_n = '0;
               if (bit_idx == BIT_W'(DATA_W - 1)) begin
                  state_n = STOP;
                  tx_n    = UART_IDLE_LVL;
               end else begin
                  bit_idx_n = bit_idx + BIT_W'(1);
                  tx_n      = shift[0];
                  shift_n   = shift >> 1;
               end
            end
         end
         STOP: begin
            cnt_n = cnt + CNT_W'(1);
            if (bit_end_c) begin
               state_n = IDLE;
               cnt_n   = '0;
               done_n  = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase

      busy_n = (state_n != IDLE);
   end

endmodule
